bool_op_sched: RTL and testbench

Round-robin scheduler that shares one combinational boolean logic unit (AND/OR/XOR/NAND over WIDTH-bit operands) among NREQ requesters. Each requester presents operands and a 2-bit mode on a valid/ready port. The scheduler grants one request per cycle, registers the result in a single-entry output stage, and returns it tagged with the requester index on a valid/ready response port. It sits between the block's operand sources and the shared logic unit, and it is the only path into that unit.

---
 rtl/bool_op_pkg.sv | 25 ++
 rtl/bool_op_unit.sv | 31 +++
 rtl/bool_op_sched.sv | 113 +++++++++++
 tb/tb_bool_op_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bool_op_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bool_op_pkg
// Brief    : Shared types for the boolean-op scheduler: operation modes and
//            output-stage states.
// Revision : 1.0 - initial release
// ============================================================================
package bool_op_pkg;

  // Operation selected by a requester's 2-bit mode field
  typedef enum logic [1:0] {
    BOOL_AND  = 2'b00,
    BOOL_OR   = 2'b01,
    BOOL_XOR  = 2'b10,
    BOOL_NAND = 2'b11
  } bool_mode_t;

  // Single-entry output stage occupancy
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage : bool_op_pkg
`default_nettype wire

// File: rtl/bool_op_unit.sv
`default_nettype none
// ============================================================================
// Module   : bool_op_unit
// Brief    : Combinational bitwise logic unit (AND / OR / XOR / NAND).
// Revision : 1.0 - initial release
// ============================================================================
module bool_op_unit
  import bool_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  bool_mode_t       mode,
  output logic [WIDTH-1:0] result
);

  // Purely bitwise evaluation; result is exactly WIDTH bits
  always_comb begin
    result = '0;
    case (mode)
      BOOL_AND:  result = x & y;
      BOOL_OR:   result = x | y;
      BOOL_XOR:  result = x ^ y;
      BOOL_NAND: result = ~(x & y);
      default:   result = '0;
    endcase
  end

endmodule : bool_op_unit
`default_nettype wire

// File: rtl/bool_op_sched.sv
`default_nettype none
// ============================================================================
// Module   : bool_op_sched
// Brief    : Round-robin scheduler sharing one bool_op_unit among NREQ
//            requesters, with a single-entry registered response stage.
// Revision : 1.0 - initial release
// ============================================================================
module bool_op_sched
  import bool_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_mode,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
);

  out_state_t          state_q;
  out_state_t          state_d;
  logic [IDW-1:0]      last_q;
  logic [IDW-1:0]      grant_idx;
  logic                grant_found;
  logic                grant_en;
  logic                can_accept;
  logic [2*NREQ-1:0]   prio_vec;
  logic [WIDTH-1:0]    sel_a;
  logic [WIDTH-1:0]    sel_b;
  bool_mode_t          sel_mode;
  logic [WIDTH-1:0]    unit_result;

  // The stage accepts when empty, or when the held result leaves this cycle
  assign can_accept = (state_q == OUT_EMPTY) || rsp_ready;

  // Doubling the valid vector lets the search run linearly from last+1 and
  // wrap naturally without a modulo on every index
  assign prio_vec = {req_valid, req_valid};

  // Round-robin search: first valid requester after the last grant
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_found && prio_vec[int'(last_q) + k]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(last_q) + k >= NREQ) ? (int'(last_q) + k - NREQ)
                                                       : (int'(last_q) + k));
      end
    end
  end

  // Nothing is accepted while reset is asserted
  assign grant_en  = grant_found && can_accept && !rst;
  assign req_ready = grant_en ? (NREQ'(1) << grant_idx) : '0;

  // Operand mux into the single shared unit
  assign sel_a    = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_b    = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_mode = bool_mode_t'(req_mode[int'(grant_idx)*2 +: 2]);

  bool_op_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .x      (sel_a),
    .y      (sel_b),
    .mode   (sel_mode),
    .result (unit_result)
  );

  // Output-stage state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  // Next state: a grant always fills; a consumed result without refill empties
  always_comb begin
    state_d = state_q;
    if (grant_en)
      state_d = OUT_FULL;
    else if (state_q == OUT_FULL && rsp_ready)
      state_d = OUT_EMPTY;
  end

  // Output decode of the stage state
  always_comb begin
    rsp_valid = (state_q == OUT_FULL);
  end

  // Result, tag and round-robin pointer capture on each grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      last_q   <= IDW'(NREQ - 1);
    end else if (grant_en) begin
      rsp_data <= unit_result;
      rsp_id   <= grant_idx;
      last_q   <= grant_idx;
    end
  end

endmodule : bool_op_sched
`default_nettype wire

// File: tb/tb_bool_op_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bool_op_sched
// Brief    : Directed self-checking bench for bool_op_sched (WIDTH=8, NREQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bool_op_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_mode;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;

  int vectors     = 0;
  int miscompares = 0;

  bool_op_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load every requester with a=0xF0, b=0x3C, mode 00
  task automatic default_payload();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = 8'hF0;
      req_b[i*WIDTH +: WIDTH] = 8'h3C;
      req_mode[i*2 +: 2]      = 2'b00;
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    default_payload();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    default_payload();
    req_valid = 4'hF;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d want v=0 d=00 id=0",
               rsp_valid, rsp_data, rsp_id);
    end
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_modes();
    logic [7:0] exp_data [4];
    exp_data[0] = 8'h30;
    exp_data[1] = 8'hFC;
    exp_data[2] = 8'hCC;
    exp_data[3] = 8'hCF;
    apply_reset();
    for (int m = 0; m < 4; m++) begin
      req_mode[2*2 +: 2] = 2'(m);
      req_valid          = 4'b0100;
      #1;
      vectors++;
      if (req_ready !== 4'b0100) begin
        miscompares++;
        $display("FAIL mode%0d_ready: got %b want 0100", m, req_ready);
      end
      step();
      req_valid = '0;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_data[m] || rsp_id !== 2'd2) begin
        miscompares++;
        $display("FAIL mode%0d_result: got v=%b d=%h id=%0d want v=1 d=%h id=2",
                 m, rsp_valid, rsp_data, rsp_id, exp_data[m]);
      end
    end
    step();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mode_drain: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      vectors++;
      if (req_ready !== (4'b0001 << exp_seq[k])) begin
        miscompares++;
        $display("FAIL rr%0d_ready: got %b want grant %0d", k, req_ready, exp_seq[k]);
      end
      step();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_seq[k]) || rsp_data !== 8'h30) begin
        miscompares++;
        $display("FAIL rr%0d_result: got v=%b id=%0d d=%h want v=1 id=%0d d=30",
                 k, rsp_valid, rsp_id, rsp_data, exp_seq[k]);
      end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_valid = 4'b0010;
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h30) begin
      miscompares++;
      $display("FAIL bp_accept: got v=%b id=%0d d=%h want v=1 id=1 d=30",
               rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready          = 1'b0;
    req_valid          = 4'hF;
    req_mode[2*2 +: 2] = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp%0d_ready: got %b want 0000", c, req_ready);
      end
      step();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h30) begin
        miscompares++;
        $display("FAIL bp%0d_hold: got v=%b id=%0d d=%h want v=1 id=1 d=30",
                 c, rsp_valid, rsp_id, rsp_data);
      end
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hFC) begin
      miscompares++;
      $display("FAIL bp_release_result: got v=%b id=%0d d=%h want v=1 id=2 d=FC",
               rsp_valid, rsp_id, rsp_data);
    end
    req_mode[2*2 +: 2] = 2'b00;
  endtask

  // Continues from the FULL state (id 2) left by test_backpressure
  task automatic test_drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: got v=%b want 0", rsp_valid);
    end
    // last must still be 2, so requester 3 wins over requester 0
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL drain_last_ready: got %b want 1000", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
      miscompares++;
      $display("FAIL drain_refill: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id);
    end
    step();
  endtask

  task automatic test_wrap_skip();
    apply_reset();
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0011;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_first_ready: got %b want 0001", req_ready);
    end
    step();
    vectors++;
    if (rsp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_first_id: got %0d want 0", rsp_id);
    end
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL wrap_second_ready: got %b want 0010", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (rsp_id !== 2'd1 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_second_id: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id);
    end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 4'b1000;
    req_mode[3*2 +: 2] = 2'b01;
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hFC || rsp_id !== 2'd3) begin
      miscompares++;
      $display("FAIL rmid_full: got v=%b d=%h id=%0d want v=1 d=FC id=3",
               rsp_valid, rsp_data, rsp_id);
    end
    rst = 1'b1;
    step();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rmid_cleared: got v=%b d=%h id=%0d want v=0 d=00 id=0",
               rsp_valid, rsp_data, rsp_id);
    end
    req_valid = 4'hF;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rmid_first_grant: got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_first_id: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id);
    end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
    req_mode  = '0;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_wrap_skip();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bool_op_sched
`default_nettype wire
